// File: rtl/inv_cipher_if.sv
// Valid/ready job interface for the iterative AES inverse cipher.
// master = block/key producer and plaintext consumer, slave = cipher core.
interface inv_cipher_if #(
  parameter int N = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in;
  logic [N-1:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;

  modport master (
    output in_valid, in, key, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, key, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES InvCipher: one inverse round per clock, AES-128/192/256.
// Latency: out_valid rises Nr edges after the acceptance edge.
module inv_cipher_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  inv_cipher_if.slave  bus,
  output logic         busy
);

  localparam int RW = $clog2(Nr);
  localparam int FW = 128 * (Nr + 1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t         state, state_n;
  logic [RW-1:0]  rnd, rnd_n;
  logic [127:0]   st, st_n;
  logic [N-1:0]   key_reg, key_n;
  logic [FW-1:0]  fk_reg;
  logic [127:0]   rk_cur;
  logic [127:0]   rk_in;
  logic           in_ready;
  logic           out_valid;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), with 0 -> 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [FW-1:0] expand(input logic [N-1:0] k);
    logic [FW-1:0] f;
    logic [31:0]   t;
    logic [7:0]    rc;
    f  = '0;
    rc = 8'h01;
    for (int i = 0; i < Nk; i++)
      f[FW-1-32*i -: 32] = k[N-1-32*i -: 32];
    for (int i = Nk; i < 4 * (Nr + 1); i++) begin
      t = f[FW-1-32*(i-1) -: 32];
      if (i % Nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = sub_word(t);
      end
      f[FW-1-32*i -: 32] = f[FW-1-32*(i-Nk) -: 32] ^ t;
    end
    return f;
  endfunction

  function automatic logic [127:0] last_rk(input logic [N-1:0] k);
    logic [FW-1:0] f;
    f = expand(k);
    return f[127:0];
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++)
      o[127-8*b -: 8] = isbox(s[127-8*b -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // rk[Nr] for the first AddRoundKey comes straight from the incoming key
  assign fk_reg = expand(key_reg);
  assign rk_in  = last_rk(bus.key);
  assign rk_cur = fk_reg[FW-1-128*int'(rnd) -: 128];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rnd     <= '0;
      st      <= '0;
      key_reg <= '0;
    end else begin
      state   <= state_n;
      rnd     <= rnd_n;
      st      <= st_n;
      key_reg <= key_n;
    end
  end

  always_comb begin
    state_n   = state;
    rnd_n     = rnd;
    st_n      = st;
    key_n     = key_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          key_n   = bus.key;
          st_n    = bus.in ^ rk_in;
          rnd_n   = RW'(Nr - 1);
          state_n = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd != '0) begin
          st_n  = inv_mix(inv_sub(inv_shift(st)) ^ rk_cur);
          rnd_n = rnd - RW'(1);
        end else begin
          st_n    = inv_sub(inv_shift(st)) ^ rk_cur;
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out       = st;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: FIPS-197 vectors on AES-128/192/256 instances
// plus backpressure, back-to-back and mid-round reset sequences.
module tb_inv_cipher_iter;

  logic clk;
  logic rst_n;

  int           sel;
  logic         iv;
  logic         ordy;
  logic [255:0] kin;
  logic [127:0] din;

  logic         cur_ov, cur_ir, cur_busy;
  logic [127:0] cur_out;
  logic         busy128, busy192, busy256;

  int checks;
  int errors;

  inv_cipher_if #(.N(128)) b128 ();
  inv_cipher_if #(.N(192)) b192 ();
  inv_cipher_if #(.N(256)) b256 ();

  assign b128.in_valid  = iv && (sel == 0);
  assign b192.in_valid  = iv && (sel == 1);
  assign b256.in_valid  = iv && (sel == 2);
  assign b128.out_ready = ordy && (sel == 0);
  assign b192.out_ready = ordy && (sel == 1);
  assign b256.out_ready = ordy && (sel == 2);
  assign b128.in        = din;
  assign b192.in        = din;
  assign b256.in        = din;
  assign b128.key       = kin[255:128];
  assign b192.key       = kin[255:64];
  assign b256.key       = kin;

  inv_cipher_iter #(.N(128), .Nr(10), .Nk(4)) u128 (
    .clk(clk), .rst_n(rst_n), .bus(b128), .busy(busy128)
  );
  inv_cipher_iter #(.N(192), .Nr(12), .Nk(6)) u192 (
    .clk(clk), .rst_n(rst_n), .bus(b192), .busy(busy192)
  );
  inv_cipher_iter #(.N(256), .Nr(14), .Nk(8)) u256 (
    .clk(clk), .rst_n(rst_n), .bus(b256), .busy(busy256)
  );

  always_comb begin
    cur_ov   = b128.out_valid;
    cur_ir   = b128.in_ready;
    cur_out  = b128.out;
    cur_busy = busy128;
    case (sel)
      1: begin
        cur_ov   = b192.out_valid;
        cur_ir   = b192.in_ready;
        cur_out  = b192.out;
        cur_busy = busy192;
      end
      2: begin
        cur_ov   = b256.out_valid;
        cur_ir   = b256.in_ready;
        cur_out  = b256.out;
        cur_busy = busy256;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           sel;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           nr;
  } vec_t;

  vec_t tv [4];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // issue one job, wait (bounded) for out_valid; n = edges after acceptance
  task automatic do_job(input int s, input logic [255:0] k,
                        input logic [127:0] c, output logic [127:0] res,
                        output int n, output int bc);
    sel = s;
    kin = k;
    din = c;
    iv  = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    n  = 0;
    bc = cur_busy ? 1 : 0;
    while (!cur_ov && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (cur_busy) bc++;
    end
    res = cur_out;
  endtask

  logic [127:0] res;
  logic [127:0] held;
  int           n, bc, gap, ovc;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    iv     = 1'b0;
    ordy   = 1'b0;
    sel    = 0;
    kin    = '0;
    din    = '0;

    tv[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 10};
    tv[1] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 10};
    tv[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                  64'h0},
              128'hdda97ca4864cdfe06eaf70a0ec0d7191,
              128'h00112233445566778899aabbccddeeff, 12};
    tv[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 14};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(cur_ov), 128'(1'b0));
    chk("rst_busy", 128'(cur_busy), 128'(1'b0));
    chk("rst_out", cur_out, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(cur_ir), 128'(1'b1));

    for (int i = 0; i < 4; i++) begin
      ordy = 1'b1;
      do_job(tv[i].sel, tv[i].key, tv[i].ct, res, n, bc);
      chk("vec_pt", res, tv[i].pt);
      chk("vec_latency", 128'(n), 128'(tv[i].nr));
      chk("vec_busy_cycles", 128'(bc), 128'(tv[i].nr));
      @(posedge clk);
      #1;
      chk("vec_ov_drop", 128'(cur_ov), 128'(1'b0));
      chk("vec_ir_back", 128'(cur_ir), 128'(1'b1));
      chk("vec_out_hold", cur_out, tv[i].pt);
    end

    // backpressure with an ignored second request
    ordy = 1'b0;
    do_job(0, tv[0].key, tv[0].ct, res, n, bc);
    chk("bp_pt", res, tv[0].pt);
    held = cur_out;
    for (int i = 0; i < 20; i++) begin
      iv  = 1'b1;
      kin = tv[1].key;
      din = tv[1].ct;
      @(posedge clk);
      #1;
      chk("bp_out_stable", cur_out, held);
      chk("bp_ov_held", 128'(cur_ov), 128'(1'b1));
      chk("bp_ir_low", 128'(cur_ir), 128'(1'b0));
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    chk("bp_ov_drop", 128'(cur_ov), 128'(1'b0));
    chk("bp_ir_back", 128'(cur_ir), 128'(1'b1));
    chk("bp_out_hold", cur_out, tv[0].pt);
    @(posedge clk);
    #1;
    chk("bp_no_new_job", 128'(cur_busy), 128'(1'b0));

    // back-to-back with in_valid held high
    sel  = 0;
    ordy = 1'b1;
    kin  = tv[0].key;
    din  = tv[0].ct;
    iv   = 1'b1;
    n    = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!cur_ov && n < 60);
    chk("b2b_first_pt", cur_out, tv[0].pt);
    kin = tv[1].key;
    din = tv[1].ct;
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!cur_ov && gap < 60);
    iv = 1'b0;
    chk("b2b_second_pt", cur_out, tv[1].pt);
    chk("b2b_gap", 128'(gap), 128'(12));
    @(posedge clk);
    #1;

    // reset pulse while rnd == 5
    ordy = 1'b0;
    sel  = 0;
    kin  = tv[1].key;
    din  = tv[1].ct;
    iv   = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 128'(cur_busy), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(cur_busy), 128'(1'b0));
    chk("mid_rst_ov", 128'(cur_ov), 128'(1'b0));
    chk("mid_rst_out", cur_out, 128'h0);
    chk("mid_rst_ir", 128'(cur_ir), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    ordy  = 1'b1;
    ovc   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (cur_ov) ovc++;
    end
    chk("mid_no_output", 128'(ovc), 128'(0));
    do_job(0, tv[1].key, tv[1].ct, res, n, bc);
    chk("mid_fresh_pt", res, tv[1].pt);
    chk("mid_fresh_latency", 128'(n), 128'(10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_cipher_iter.md
Name: inv_cipher_iter

Overview:
Iterative AES inverse cipher (FIPS-197 InvCipher), the decryption counterpart of the team's combinational encryption datapath. It accepts one 128-bit ciphertext block plus key over a valid/ready handshake and executes one inverse round per clock. It returns the plaintext over a valid/ready handshake with output backpressure. Supports AES-128/192/256 through the same N/Nr/Nk parameter set as the encryption path.

Parameters:
N, 128, key width in bits (128/192/256)
Nr, 10, number of rounds (10/12/14)
Nk, 4, key length in 32-bit words (4/6/8)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext and key are valid
in_ready  output  1  block can accept a new job
in  input  128  ciphertext, byte 0 in [127:120]
key  input  N  cipher key, sampled with in
out_valid  output  1  plaintext on out is valid
out_ready  input  1  consumer accepts out
out  output  128  plaintext, byte 0 in [127:120]
busy  output  1  high in ROUND state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 after release; out_valid=0; out=0; busy=0; round counter=0; state and key registers=0. Reset mid-operation abandons the job; no output is produced.
- Round keys: the registered key drives the existing keyExpantion(Nk,Nr) instance. rk[i] = fullkeys[128*(Nr+1)-1-128*i -: 128], i=0..Nr.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: key_reg<=key; st<=in ^ rk[Nr], computed from the incoming key through a second combinational expansion path or equivalent; rnd<=Nr-1; go ROUND.
  - Implementation choice allowed: register the key first and add one cycle. If taken, latency is +1 and must be documented in a header parameter LAT.
- FSM ROUND:
  - in_ready=0; busy=1.
  - For rnd>=1: st<=InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[rnd]); rnd<=rnd-1.
  - For rnd==0: st<=InvSubBytes(InvShiftRows(st)) ^ rk[0]; go DONE.
- FSM DONE:
  - out_valid=1; out=st; out and out_valid stable until out_ready.
  - On out_ready: out_valid<=0 next cycle; go IDLE.
  - in_ready=0 while in DONE; no overlap of jobs.
- Latency: acceptance edge at T gives out_valid=1 after edge T+Nr (11 edges total for AES-128). Throughput is one block per Nr+2 cycles minimum with out_ready tied high.
- in and key are ignored when in_ready=0; in_valid may drop without effect.
- out_ready held high before DONE has no effect. out_ready is sampled only while out_valid=1.
- out register holds the last plaintext after the handshake; only out_valid drops.
- Inverse transforms:
  - InvShiftRows: row r rotates right by r.
  - InvSubBytes: inverse S-box, combinational ROM.
  - InvMixColumns: GF(2^8) multiply by {0e,0b,0d,09}, poly 0x11B. All logic is combinational within one cycle.
- rnd width is clog2(Nr) bits; it never wraps because rnd==0 exits ROUND.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32, out_ready=1 -> out 3243f6a8885a308d313198a2e0370734; out_valid rises exactly Nr=10 edges after acceptance; busy high for 10 cycles.
- AES-128 (C.1), key 000102…0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff.
- N=192/Nr=12/Nk=6, key 000102…17, in dda97ca4864cdfe06eaf70a0ec0d7191 -> out 00112233445566778899aabbccddeeff. N=256/Nr=14/Nk=8, key 000102…1f, in 8ea2b7ca516745bfeafc49904b496089 -> same out.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 the next cycle.
- Back-to-back jobs, in_valid held high with two different ciphertexts -> second accepted the cycle after DONE exits; both plaintexts correct.
- rst_n pulsed low mid-ROUND (rnd=5) -> all outputs reset immediately; no out_valid follows. A subsequent fresh job decrypts correctly.
